// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit: access-size
// encodings, FSM states, and byte-enable / store-lane / alignment helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    MEMOP_WORD = 2'b00,
    MEMOP_HALF = 2'b01,
    MEMOP_BYTE = 2'b10,
    MEMOP_RSVD = 2'b11
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mau_state_t;

  localparam int CNT_W = 8;

  function automatic logic [3:0] byte_en(input mem_op_t op, input logic [1:0] lane);
    logic [3:0] be;
    case (op)
      MEMOP_BYTE: be = 4'b0001 << lane;
      MEMOP_HALF: be = 4'b0011 << {lane[1], 1'b0};
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input mem_op_t op, input logic [31:0] data);
    logic [31:0] w;
    case (op)
      MEMOP_BYTE: w = {4{data[7:0]}};
      MEMOP_HALF: w = {2{data[15:0]}};
      default:    w = data;
    endcase
    return w;
  endfunction

  // Reserved size behaves as a word, so it carries the word alignment rule.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lane);
    logic m;
    case (op)
      MEMOP_BYTE: m = 1'b0;
      MEMOP_HALF: m = lane[0];
      default:    m = (lane != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Load formatter: picks the addressed byte/halfword out of the bus word and
// sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  mem_op_t     i_size,
  input  logic        i_ext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select (little-endian) followed by extension.
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_data = i_rdata;
    case (i_lane)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_lane[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
    case (i_size)
      MEMOP_BYTE: o_data = {{24{i_ext & w_byte[7]}}, w_byte};
      MEMOP_HALF: o_data = {{16{i_ext & w_half[15]}}, w_half};
      default:    o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues req/ack bus accesses, formats loads,
// stalls the pipeline while an access is outstanding, reports faults.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              MEM_aluResult,
  input  logic [1:0]               MEM_MemOp,
  input  logic                     MEM_MemEXT,
  input  logic                     MEM_MemWrite,
  input  logic                     MEM_MemRead,
  input  logic [31:0]              MEM_rfOut2,
  input  logic [31:0]              MEM_PC,
  mem_access_unit_if.master        bus,
  output logic [31:0]              load_data,
  output logic                     mem_stall,
  output logic                     mem_done,
  output logic                     align_err,
  output logic                     bus_err,
  output logic [31:0]              err_pc
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  mau_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  mem_op_t          r_size;
  logic             r_ext;
  logic [1:0]       r_lane;
  logic [31:0]      r_load;
  logic             r_done;
  logic             r_align_err;
  logic             r_bus_err;
  logic [31:0]      r_err_pc;

  logic             w_access;
  logic             w_misal;
  mem_op_t          w_op;
  logic [31:0]      w_fmt;

  assign w_access = MEM_MemRead | MEM_MemWrite;
  assign w_op     = mem_op_t'(MEM_MemOp);
  assign w_misal  = is_misaligned(w_op, MEM_aluResult[1:0]);

  // Stall covers the detect cycle and every BUSY cycle; DONE lets the pipe move.
  assign mem_stall = ((r_state == ST_IDLE) && w_access && !w_misal) ||
                     (r_state == ST_BUSY);

  mem_load_align u_align (
    .i_rdata (bus.dm_rdata),
    .i_lane  (r_lane),
    .i_size  (r_size),
    .i_ext   (r_ext),
    .o_data  (w_fmt)
  );

  // Access FSM with registered bus outputs, load result and fault reporting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0000_0000;
      r_be        <= 4'b0000;
      r_wdata     <= 32'h0000_0000;
      r_size      <= MEMOP_WORD;
      r_ext       <= 1'b0;
      r_lane      <= 2'b00;
      r_load      <= 32'h0000_0000;
      r_done      <= 1'b0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
      r_err_pc    <= 32'h0000_0000;
    end else begin
      r_done      <= 1'b0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access && w_misal) begin
            r_align_err <= 1'b1;
            r_err_pc    <= MEM_PC;
          end else if (w_access) begin
            r_req   <= 1'b1;
            r_we    <= MEM_MemWrite;
            r_addr  <= {MEM_aluResult[31:2], 2'b00};
            r_be    <= byte_en(w_op, MEM_aluResult[1:0]);
            r_wdata <= store_lanes(w_op, MEM_rfOut2);
            r_size  <= w_op;
            r_ext   <= MEM_MemEXT;
            r_lane  <= MEM_aluResult[1:0];
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // An ack arriving on the last allowed cycle still wins over timeout.
          if (bus.dm_ack) begin
            r_req  <= 1'b0;
            r_done <= 1'b1;
            if (!r_we) begin
              r_load <= w_fmt;
            end else begin
              r_load <= r_load;
            end
            r_state <= ST_DONE;
          end else if (r_cnt == LAST_CNT) begin
            r_req     <= 1'b0;
            r_done    <= 1'b1;
            r_bus_err <= 1'b1;
            r_err_pc  <= MEM_PC;
            r_state   <= ST_DONE;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dm_req   = r_req;
  assign bus.dm_we    = r_we;
  assign bus.dm_addr  = r_addr;
  assign bus.dm_be    = r_be;
  assign bus.dm_wdata = r_wdata;
  assign load_data    = r_load;
  assign mem_done     = r_done;
  assign align_err    = r_align_err;
  assign bus_err      = r_bus_err;
  assign err_pc       = r_err_pc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit (TIMEOUT=4), plus a
// hand-written reset-during-BUSY sequence.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [31:0] MEM_aluResult;
  logic [1:0]  MEM_MemOp;
  logic        MEM_MemEXT;
  logic        MEM_MemWrite;
  logic        MEM_MemRead;
  logic [31:0] MEM_rfOut2;
  logic [31:0] MEM_PC;
  logic [31:0] load_data;
  logic        mem_stall;
  logic        mem_done;
  logic        align_err;
  logic        bus_err;
  logic [31:0] err_pc;

  int checks;
  int failures;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .MEM_aluResult (MEM_aluResult),
    .MEM_MemOp     (MEM_MemOp),
    .MEM_MemEXT    (MEM_MemEXT),
    .MEM_MemWrite  (MEM_MemWrite),
    .MEM_MemRead   (MEM_MemRead),
    .MEM_rfOut2    (MEM_rfOut2),
    .MEM_PC        (MEM_PC),
    .bus           (bus_if),
    .load_data     (load_data),
    .mem_stall     (mem_stall),
    .mem_done      (mem_done),
    .align_err     (align_err),
    .bus_err       (bus_err),
    .err_pc        (err_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  op;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    int          waits;
    logic [31:0] rdata;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    int          e_stall;
    int          e_req;
    logic [31:0] e_ld;
    logic        e_align;
    logic        e_buserr;
    logic [31:0] e_errpc;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic rd, input logic wr, input logic [1:0] op, input logic ext,
    input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc,
    input int waits, input logic [31:0] rdata,
    input logic [3:0] e_be, input logic [31:0] e_addr, input logic [31:0] e_wdata,
    input logic e_we, input int e_stall, input int e_req, input logic [31:0] e_ld,
    input logic e_align, input logic e_buserr, input logic [31:0] e_errpc);
    vec_t v;
    v.rd = rd; v.wr = wr; v.op = op; v.ext = ext; v.addr = addr; v.wdata = wdata;
    v.pc = pc; v.waits = waits; v.rdata = rdata; v.e_be = e_be; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_we = e_we; v.e_stall = e_stall; v.e_req = e_req;
    v.e_ld = e_ld; v.e_align = e_align; v.e_buserr = e_buserr; v.e_errpc = e_errpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    MEM_aluResult = 32'h0000_0000;
    MEM_MemOp     = 2'b00;
    MEM_MemEXT    = 1'b0;
    MEM_MemWrite  = 1'b0;
    MEM_MemRead   = 1'b0;
    MEM_rfOut2    = 32'h0000_0000;
    MEM_PC        = 32'h0000_0000;
  endtask

  // Entered just after a rising edge; returns just after a rising edge.
  task automatic run_vec(input int idx, input vec_t v);
    int stall_n;
    int req_n;
    bit fin;
    stall_n = 0;
    req_n   = 0;
    fin     = 1'b0;
    MEM_aluResult = v.addr;
    MEM_MemOp     = v.op;
    MEM_MemEXT    = v.ext;
    MEM_MemWrite  = v.wr;
    MEM_MemRead   = v.rd;
    MEM_rfOut2    = v.wdata;
    MEM_PC        = v.pc;
    for (int c = 0; c < 30 && !fin; c++) begin
      #1;
      if (mem_stall) stall_n++;
      if (bus_if.dm_req) begin
        chk($sformatf("v%0d_be", idx),    {28'h0, bus_if.dm_be}, {28'h0, v.e_be});
        chk($sformatf("v%0d_addr", idx),  bus_if.dm_addr, v.e_addr);
        chk($sformatf("v%0d_we", idx),    {31'h0, bus_if.dm_we}, {31'h0, v.e_we});
        chk($sformatf("v%0d_wdata", idx), bus_if.dm_wdata, v.e_wdata);
        if (req_n == v.waits) begin
          bus_if.dm_ack   = 1'b1;
          bus_if.dm_rdata = v.rdata;
        end
        req_n++;
      end
      @(posedge clk);
      #1;
      bus_if.dm_ack   = 1'b0;
      bus_if.dm_rdata = 32'h5A5A_5A5A;
      if (mem_done || align_err || bus_err) fin = 1'b1;
    end
    chk($sformatf("v%0d_finished", idx), {31'h0, fin}, 32'h0000_0001);
    chk($sformatf("v%0d_stall_cycles", idx), 32'(stall_n), 32'(v.e_stall));
    chk($sformatf("v%0d_req_cycles", idx),   32'(req_n),   32'(v.e_req));
    chk($sformatf("v%0d_load_data", idx), load_data, v.e_ld);
    chk($sformatf("v%0d_mem_done", idx),  {31'h0, mem_done},  {31'h0, ~v.e_align});
    chk($sformatf("v%0d_align_err", idx), {31'h0, align_err}, {31'h0, v.e_align});
    chk($sformatf("v%0d_bus_err", idx),   {31'h0, bus_err},   {31'h0, v.e_buserr});
    chk($sformatf("v%0d_err_pc", idx),    err_pc, v.e_errpc);
    if (v.e_align) begin
      idle_inputs();
    end else begin
      #1;
      chk($sformatf("v%0d_done_stall", idx), {31'h0, mem_stall}, 32'h0000_0000);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    chk($sformatf("v%0d_pulse_clear", idx),
        {29'h0, mem_done, align_err, bus_err}, 32'h0000_0000);
    chk($sformatf("v%0d_no_reissue", idx), {31'h0, bus_if.dm_req}, 32'h0000_0000);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    bus_if.dm_ack   = 1'b0;
    bus_if.dm_rdata = 32'h0000_0000;
    rst = 1'b0;

    //                rd    wr    op     ext   addr          wdata         pc            w    rdata
    //                be       addr          wdata         we    st rq ld            al    be    errpc
    vecs[0]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_1000, 0, 32'hDEAD_BEEF,
                  4'b1111, 32'h0000_0100, 32'h0000_0000, 1'b0, 2, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0000_0000, 32'h0000_1004, 0, 32'h8000_0000,
                  4'b1000, 32'h0000_0100, 32'h0000_0000, 1'b0, 2, 1, 32'hFFFF_FF80, 1'b0, 1'b0, 32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0000_0000, 32'h0000_1008, 0, 32'h8000_0000,
                  4'b1000, 32'h0000_0100, 32'h0000_0000, 1'b0, 2, 1, 32'h0000_0080, 1'b0, 1'b0, 32'h0);
    vecs[3]  = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 32'h0000_100C, 3, 32'h0000_0000,
                  4'b1100, 32'h0000_0100, 32'hABCD_ABCD, 1'b1, 5, 4, 32'h0000_0080, 1'b0, 1'b0, 32'h0);
    vecs[4]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_0000, 32'h0000_0040, 0, 32'h0000_0000,
                  4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 0, 32'h0000_0080, 1'b1, 1'b0, 32'h40);
    vecs[5]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0000_0000, 32'h0000_0080, 255, 32'h0000_0000,
                  4'b1111, 32'h0000_0200, 32'h0000_0000, 1'b0, 5, 4, 32'h0000_0080, 1'b0, 1'b1, 32'h80);
    vecs[6]  = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0106, 32'h0000_0000, 32'h0000_1010, 1, 32'h8001_7FFF,
                  4'b1100, 32'h0000_0104, 32'h0000_0000, 1'b0, 3, 2, 32'hFFFF_8001, 1'b0, 1'b0, 32'h80);
    vecs[7]  = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0104, 32'h0000_0000, 32'h0000_1014, 0, 32'h8001_7FFF,
                  4'b0011, 32'h0000_0104, 32'h0000_0000, 1'b0, 2, 1, 32'h0000_7FFF, 1'b0, 1'b0, 32'h80);
    vecs[8]  = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0301, 32'h0000_00A5, 32'h0000_1018, 0, 32'h0000_0000,
                  4'b0010, 32'h0000_0300, 32'hA5A5_A5A5, 1'b1, 2, 1, 32'h0000_7FFF, 1'b0, 1'b0, 32'h80);
    vecs[9]  = mk(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 32'h0000_101C, 0, 32'h1111_1111,
                  4'b1111, 32'h0000_0400, 32'hCAFE_F00D, 1'b1, 2, 1, 32'h0000_7FFF, 1'b0, 1'b0, 32'h80);
    vecs[10] = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_0000, 32'h0000_0044, 0, 32'h0000_0000,
                  4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 0, 32'h0000_7FFF, 1'b1, 1'b0, 32'h44);
    vecs[11] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0000_0000, 32'h0000_1020, 0, 32'h00FF_0000,
                  4'b0100, 32'h0000_0100, 32'h0000_0000, 1'b0, 2, 1, 32'h0000_00FF, 1'b0, 1'b0, 32'h44);
    vecs[12] = mk(1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_0108, 32'h0000_0000, 32'h0000_1024, 0, 32'h1234_5678,
                  4'b1111, 32'h0000_0108, 32'h0000_0000, 1'b0, 2, 1, 32'h1234_5678, 1'b0, 1'b0, 32'h44);
    vecs[13] = mk(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0101, 32'h0000_0000, 32'h0000_1028, 0, 32'h0000_7F00,
                  4'b0010, 32'h0000_0100, 32'h0000_0000, 1'b0, 2, 1, 32'h0000_007F, 1'b0, 1'b0, 32'h44);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_req",   {31'h0, bus_if.dm_req}, 32'h0);
    chk("reset_be",    {28'h0, bus_if.dm_be},  32'h0);
    chk("reset_load",  load_data, 32'h0);
    chk("reset_errpc", err_pc,    32'h0);
    chk("reset_stall", {31'h0, mem_stall}, 32'h0);

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset arriving in the middle of a BUSY access abandons it.
    MEM_aluResult = 32'h0000_0500;
    MEM_MemRead   = 1'b1;
    MEM_MemOp     = 2'b00;
    MEM_PC        = 32'h0000_2000;
    @(posedge clk);
    #1;
    chk("rstbusy_req_before", {31'h0, bus_if.dm_req}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    chk("rstbusy_req",   {31'h0, bus_if.dm_req}, 32'h0);
    chk("rstbusy_addr",  bus_if.dm_addr, 32'h0);
    chk("rstbusy_be",    {28'h0, bus_if.dm_be}, 32'h0);
    chk("rstbusy_load",  load_data, 32'h0);
    chk("rstbusy_errpc", err_pc, 32'h0);
    chk("rstbusy_stall", {31'h0, mem_stall}, 32'h0);
    rst = 1'b1;
    bus_if.dm_ack   = 1'b1;
    bus_if.dm_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus_if.dm_ack = 1'b0;
    chk("late_ack_done", {31'h0, mem_done}, 32'h0);
    chk("late_ack_load", load_data, 32'h0);
    chk("late_ack_req",  {31'h0, bus_if.dm_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
